// File: rtl/ibex_pmp_csr.sv
// PMP CSR register file: owns pmpcfg/pmpaddr/mseccfg, applies lock, TOR
// lock-through, WARL and Smepmp write rules, and presents registered
// configuration to the PMP checker.

package ibex_pmp_csr_pkg;

    typedef enum logic [1:0] {
        PMP_MODE_OFF   = 2'b00,
        PMP_MODE_TOR   = 2'b01,
        PMP_MODE_NA4   = 2'b10,
        PMP_MODE_NAPOT = 2'b11
    } pmp_cfg_mode_e;

    typedef struct packed {
        logic          lock;
        pmp_cfg_mode_e mode;
        logic          exec;
        logic          write;
        logic          read;
    } pmp_cfg_t;

    typedef struct packed {
        logic rlb;
        logic mmwp;
        logic mml;
    } pmp_mseccfg_t;

endpackage

module ibex_pmp_csr
    import ibex_pmp_csr_pkg::*;
#(
    parameter int PMPGranularity = 0,
    parameter int PMPNumRegions  = 4
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         csr_we_i,
    input  logic [11:0]  csr_addr_i,
    input  logic [31:0]  csr_wdata_i,
    output logic [31:0]  csr_rdata_o,
    output logic         csr_hit_o,
    output logic         csr_wr_ignored_o,
    output pmp_cfg_t     csr_pmp_cfg_o  [PMPNumRegions],
    output logic [33:0]  csr_pmp_addr_o [PMPNumRegions],
    output pmp_mseccfg_t csr_pmp_mseccfg_o
);

    pmp_cfg_t     cfg_q  [PMPNumRegions];
    pmp_cfg_t     cfg_d  [PMPNumRegions];
    logic [31:0]  addr_q [PMPNumRegions];
    logic [31:0]  addr_d [PMPNumRegions];
    logic [31:0]  addr_rd[PMPNumRegions];
    pmp_mseccfg_t mseccfg_q, mseccfg_d;
    logic         wr_ignored_q, wr_ignored_d;
    logic         sel_cfg, sel_addr, sel_sec;
    logic         any_lock;

    // Unpack a written pmpcfg byte into an entry, legalising NA4 when the
    // granule is larger than 4 bytes. Reserved bits 6:5 are simply not stored.
    function automatic pmp_cfg_t cfg_from_byte(input logic [7:0] b);
        pmp_cfg_t c;
        c.lock  = b[7];
        c.mode  = pmp_cfg_mode_e'(b[4:3]);
        c.exec  = b[2];
        c.write = b[1];
        c.read  = b[0];
        if (PMPGranularity > 0 && c.mode == PMP_MODE_NA4) begin
            c.mode = PMP_MODE_OFF;
        end
        return c;
    endfunction

    function automatic logic [7:0] cfg_to_byte(input pmp_cfg_t c);
        return {c.lock, 2'b00, c.mode, c.exec, c.write, c.read};
    endfunction

    // A byte write is dropped on lock, on the reserved R=0/W=1 encoding
    // outside MML, or when MML forbids creating a new M-mode executable rule.
    function automatic logic cfg_byte_dropped(input pmp_cfg_t cur, input logic [7:0] b,
                                              input pmp_mseccfg_t sec);
        logic shared_enc;
        shared_enc = ~b[0] & b[1];
        return (cur.lock & ~sec.rlb)
             | (~sec.mml & shared_enc)
             | (sec.mml & ~sec.rlb & b[7] & b[2] & ~shared_enc);
    endfunction

    assign sel_cfg   = (csr_addr_i[11:2] == 10'h0E8);
    assign sel_addr  = (csr_addr_i[11:4] == 8'h3B);
    assign sel_sec   = (csr_addr_i == 12'h747);
    assign csr_hit_o = sel_cfg | sel_addr | sel_sec;

    // RLB may only be changed while it is set or no implemented entry is locked.
    always_comb begin
        any_lock = 1'b0;
        for (int i = 0; i < PMPNumRegions; i++) begin
            any_lock = any_lock | cfg_q[i].lock;
        end
    end

    // Next-state: apply every write rule against the pre-write state.
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    always_comb begin
        cfg_d        = cfg_q;
        addr_d       = addr_q;
        mseccfg_d    = mseccfg_q;
        wr_ignored_d = 1'b0;
        if (csr_we_i) begin
            if (sel_cfg) begin
                for (int i = 0; i < PMPNumRegions; i++) begin
                    if (i[3:2] == csr_addr_i[1:0]) begin
                        if (cfg_byte_dropped(cfg_q[i], csr_wdata_i[8*(i%4) +: 8], mseccfg_q)) begin
                            wr_ignored_d = 1'b1;
                        end else begin
                            cfg_d[i] = cfg_from_byte(csr_wdata_i[8*(i%4) +: 8]);
                        end
                    end
                end
            end else if (sel_addr) begin
                for (int i = 0; i < PMPNumRegions; i++) begin
                    if (i[3:0] == csr_addr_i[3:0]) begin
                        if ((cfg_q[i].lock & ~mseccfg_q.rlb) ||
                            (i + 1 < PMPNumRegions && cfg_q[(i+1)%PMPNumRegions].mode == PMP_MODE_TOR &&
                             cfg_q[(i+1)%PMPNumRegions].lock && !mseccfg_q.rlb)) begin
                            wr_ignored_d = 1'b1;
                        end else begin
                            addr_d[i] = csr_wdata_i;
                        end
                    end
                end
            end else if (sel_sec) begin
                mseccfg_d.mml  = mseccfg_q.mml  | csr_wdata_i[0];
                mseccfg_d.mmwp = mseccfg_q.mmwp | csr_wdata_i[1];
                if (mseccfg_q.rlb || !any_lock) begin
                    mseccfg_d.rlb = csr_wdata_i[2];
                end else if (csr_wdata_i[2] != mseccfg_q.rlb) begin
                    wr_ignored_d = 1'b1;
                end
            end
        end
    end

    // Read view of pmpaddr: granule bits forced according to the entry mode.
    always_comb begin
        for (int i = 0; i < PMPNumRegions; i++) begin
            addr_rd[i] = addr_q[i];
            for (int b = 0; b < PMPGranularity; b++) begin
                if (cfg_q[i].mode == PMP_MODE_NAPOT) begin
                    if (b < PMPGranularity - 1) addr_rd[i][b] = 1'b1;
                end else begin
                    addr_rd[i][b] = 1'b0;
                end
            end
        end
    end

    // Combinational read mux over current state; zero on a miss.
    always_comb begin
        csr_rdata_o = '0;
        if (sel_cfg) begin
            for (int i = 0; i < PMPNumRegions; i++) begin
                if (i[3:2] == csr_addr_i[1:0]) csr_rdata_o[8*(i%4) +: 8] = cfg_to_byte(cfg_q[i]);
            end
        end else if (sel_addr) begin
            for (int i = 0; i < PMPNumRegions; i++) begin
                if (i[3:0] == csr_addr_i[3:0]) csr_rdata_o = addr_rd[i];
            end
        end else if (sel_sec) begin
            csr_rdata_o = {29'b0, mseccfg_q};
        end
    end

    // State registers.
    // NOTE: the entry arrays are flops, not RAM, so every element is reset
    // and non-blocking assignments keep the update order-independent.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < PMPNumRegions; i++) begin
                cfg_q[i]  <= '0;
                addr_q[i] <= '0;
            end
            mseccfg_q    <= '0;
            wr_ignored_q <= 1'b0;
        end else begin
            cfg_q        <= cfg_d;
            addr_q       <= addr_d;
            mseccfg_q    <= mseccfg_d;
            wr_ignored_q <= wr_ignored_d;
        end
    end

    assign csr_wr_ignored_o  = wr_ignored_q;
    assign csr_pmp_mseccfg_o = mseccfg_q;
    assign csr_pmp_cfg_o     = cfg_q;

    for (genvar g = 0; g < PMPNumRegions; g++) begin : g_addr_out
        assign csr_pmp_addr_o[g] = {addr_q[g], 2'b00};
    end

endmodule

// File: tb/tb_ibex_pmp_csr.sv
// Self-checking bench for ibex_pmp_csr: vector table on a G=0 instance plus
// hand sequences for reset, RLB and a G=2 instance sharing the same bus.

module tb_ibex_pmp_csr;
    import ibex_pmp_csr_pkg::*;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         we = 1'b0;
    logic [11:0]  addr = '0;
    logic [31:0]  wdata = '0;

    logic [31:0]  rdata, rdata_g2;
    logic         hit, hit_g2, ign, ign_g2;
    pmp_cfg_t     cfg_o [N];
    pmp_cfg_t     cfg_o_g2 [N];
    logic [33:0]  addr_o [N];
    logic [33:0]  addr_o_g2 [N];
    pmp_mseccfg_t sec_o, sec_o_g2;

    ibex_pmp_csr #(.PMPGranularity(0), .PMPNumRegions(N)) dut (
        .clk_i(clk), .rst_i(rst), .csr_we_i(we), .csr_addr_i(addr), .csr_wdata_i(wdata),
        .csr_rdata_o(rdata), .csr_hit_o(hit), .csr_wr_ignored_o(ign),
        .csr_pmp_cfg_o(cfg_o), .csr_pmp_addr_o(addr_o), .csr_pmp_mseccfg_o(sec_o)
    );

    ibex_pmp_csr #(.PMPGranularity(2), .PMPNumRegions(N)) dut_g2 (
        .clk_i(clk), .rst_i(rst), .csr_we_i(we), .csr_addr_i(addr), .csr_wdata_i(wdata),
        .csr_rdata_o(rdata_g2), .csr_hit_o(hit_g2), .csr_wr_ignored_o(ign_g2),
        .csr_pmp_cfg_o(cfg_o_g2), .csr_pmp_addr_o(addr_o_g2), .csr_pmp_mseccfg_o(sec_o_g2)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [11:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        logic        exp_ign;
        logic        chk_ign;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic void add(input logic w, input logic [11:0] a, input logic [31:0] d,
                                input logic [31:0] rd, input logic ig, input logic ci);
        vec_t v;
        v.we = w; v.addr = a; v.wdata = d; v.exp_rd = rd; v.exp_ign = ig; v.chk_ign = ci;
        vecs.push_back(v);
    endfunction

    // One bus cycle, then the ignore pulse and the read-back are both visible.
    task automatic cycle(input logic w, input logic [11:0] a, input logic [31:0] d);
        @(negedge clk);
        we = w; addr = a; wdata = d;
        @(negedge clk);
        we = 1'b0;
        #1;
    endtask

    task automatic run_vecs(input string tag);
        for (int k = 0; k < vecs.size(); k++) begin
            cycle(vecs[k].we, vecs[k].addr, vecs[k].wdata);
            if (vecs[k].chk_ign) check($sformatf("%s[%0d] ignored", tag, k), 64'(ign), 64'(vecs[k].exp_ign));
            check($sformatf("%s[%0d] rdata %h", tag, k, vecs[k].addr), 64'(rdata), 64'(vecs[k].exp_rd));
        end
        vecs.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1 rst = 1'b1;
        #2 rst = 1'b0;
    endtask

    logic [11:0] hit_addrs [11];
    logic        hit_exp   [11];

    initial begin
        hit_addrs = '{12'h3A0, 12'h3A3, 12'h3B0, 12'h3BF, 12'h747,
                      12'h39F, 12'h3A4, 12'h3AF, 12'h3C0, 12'h746, 12'h748};
        hit_exp   = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

        #12 rst = 1'b0;

        // Reset state on the checker-facing outputs.
        #1;
        for (int i = 0; i < N; i++) begin
            check($sformatf("reset cfg_o[%0d]", i), 64'(cfg_o[i]), 64'd0);
            check($sformatf("reset addr_o[%0d]", i), 64'(addr_o[i]), 64'd0);
        end
        check("reset mseccfg_o", 64'(sec_o), 64'd0);
        check("reset ignored", 64'(ign), 64'd0);

        // Address decode.
        for (int k = 0; k < 11; k++) begin
            addr = hit_addrs[k];
            #1 check($sformatf("hit %h", hit_addrs[k]), 64'(hit), 64'(hit_exp[k]));
        end

        // Same-address read during the write cycle returns the old value.
        @(negedge clk);
        we = 1'b1; addr = 12'h3B1; wdata = 32'h77;
        #1 check("rd during write old", 64'(rdata), 64'd0);
        check("addr_o before edge", 64'(addr_o[1]), 64'd0);
        @(negedge clk);
        we = 1'b0;
        #1 check("rd after write new", 64'(rdata), 64'h77);
        check("addr_o after edge", 64'(addr_o[1]), 64'h1DC);

        // Main table on the G=0 instance.
        add(1'b0, 12'h3A0, 32'h0,         32'h0,         1'b0, 1'b1);
        add(1'b0, 12'h3B0, 32'h0,         32'h0,         1'b0, 1'b1);
        add(1'b0, 12'h747, 32'h0,         32'h0,         1'b0, 1'b1);
        add(1'b0, 12'h3BF, 32'h0,         32'h0,         1'b0, 1'b1);
        add(1'b1, 12'h3B2, 32'hABCD,      32'hABCD,      1'b0, 1'b1);
        add(1'b1, 12'h3A0, 32'h0000_0200, 32'h0,         1'b1, 1'b1); // reserved R=0,W=1
        add(1'b1, 12'h3A0, 32'h0000_0089, 32'h89,        1'b0, 1'b1); // entry0 TOR, L, R
        add(1'b1, 12'h3B0, 32'h1234,      32'h0,         1'b1, 1'b1); // locked addr
        add(1'b1, 12'h3A0, 32'h0,         32'h89,        1'b1, 1'b1); // locked byte
        add(1'b1, 12'h3A0, 32'h0000_0100, 32'h0000_0189, 1'b1, 1'b1); // partial drop
        add(1'b1, 12'h3B1, 32'h5555,      32'h5555,      1'b0, 1'b1);
        add(1'b1, 12'h3A0, 32'h0089_0100, 32'h0089_0189, 1'b1, 1'b1); // entry2 TOR, L
        add(1'b1, 12'h3B1, 32'h7777,      32'h5555,      1'b1, 1'b1); // TOR lock-through
        add(1'b1, 12'h3B3, 32'h9999,      32'h9999,      1'b0, 1'b1); // last entry, no upper
        add(1'b1, 12'h3B2, 32'h1,         32'hABCD,      1'b1, 1'b1);
        add(1'b1, 12'h747, 32'h4,         32'h0,         1'b1, 1'b1); // RLB blocked by lock
        add(1'b1, 12'h747, 32'h3,         32'h3,         1'b0, 1'b1);
        add(1'b1, 12'h747, 32'h0,         32'h3,         1'b0, 1'b0); // sticky
        add(1'b1, 12'h3A0, 32'h8489_0289, 32'h0089_0289, 1'b1, 1'b1); // MML: 0x02 ok, 0x84 dropped
        add(1'b1, 12'h3A0, 32'h8689_0289, 32'h8689_0289, 1'b1, 1'b1); // MML: L,X,W shared ok
        add(1'b1, 12'h3B4, 32'h1,         32'h0,         1'b0, 1'b1); // unimplemented entry
        add(1'b1, 12'h300, 32'hFFFF,      32'h0,         1'b0, 1'b1); // non-hit write
        run_vecs("main");

        check("cfg_o[0]", 64'(cfg_o[0]), 64'h29);
        check("cfg_o[1]", 64'(cfg_o[1]), 64'h02);
        check("cfg_o[2]", 64'(cfg_o[2]), 64'h29);
        check("mseccfg_o", 64'(sec_o), 64'h3);
        check("addr_o[2]", 64'(addr_o[2]), 64'h2AF34);

        // Asynchronous reset mid-sequence clears state without a clock edge.
        @(negedge clk);
        addr = 12'h3A0;
        #1 rst = 1'b1;
        #1 check("async rst cfg", 64'(rdata), 64'd0);
        check("async rst mseccfg", 64'(sec_o), 64'd0);
        check("async rst addr_o", 64'(addr_o[2]), 64'd0);
        #1 rst = 1'b0;

        // RLB set with no locks keeps entry0 writable after locking it.
        add(1'b1, 12'h747, 32'h4,         32'h4,         1'b0, 1'b1);
        add(1'b1, 12'h3A0, 32'h89,        32'h89,        1'b0, 1'b1);
        add(1'b1, 12'h3A0, 32'h8D,        32'h8D,        1'b0, 1'b1);
        add(1'b1, 12'h3B0, 32'h42,        32'h42,        1'b0, 1'b1);
        add(1'b1, 12'h747, 32'h0,         32'h0,         1'b0, 1'b1); // RLB cleared while set
        add(1'b1, 12'h3A0, 32'h0,         32'h8D,        1'b1, 1'b1); // now locked
        run_vecs("rlb");

        // Granularity 2 instance.
        do_reset();
        cycle(1'b1, 12'h3A0, 32'h10);
        check("g2 NA4->OFF", 64'(rdata_g2), 64'h0);
        check("g0 NA4 kept", 64'(rdata), 64'h10);
        cycle(1'b1, 12'h3A0, 32'h18);
        check("g2 NAPOT cfg", 64'(rdata_g2), 64'h18);
        check("g2 cfg_o mode", 64'(cfg_o_g2[0].mode), 64'(PMP_MODE_NAPOT));
        cycle(1'b1, 12'h3B0, 32'h1000);
        check("g2 NAPOT addr rd", 64'(rdata_g2), 64'h1001);
        check("g2 addr_o raw", 64'(addr_o_g2[0]), 64'h4000);
        check("g0 addr rd", 64'(rdata), 64'h1000);
        cycle(1'b1, 12'h3A0, 32'h08);
        cycle(1'b1, 12'h3B0, 32'h1003);
        check("g2 TOR addr rd", 64'(rdata_g2), 64'h1000);
        check("g2 TOR addr_o", 64'(addr_o_g2[0]), 64'h400C);
        check("g0 TOR addr rd", 64'(rdata), 64'h1003);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ibex_pmp_csr.md
# ibex_pmp_csr

PMP CSR register file that owns the `pmpcfg`, `pmpaddr` and `mseccfg` machine CSRs and drives the PMP checker's configuration inputs. It applies all write-side rules on every CSR write from the core's CSR unit and presents registered configuration to the checker: lock, TOR lock-through, WARL legalisation, Smepmp sticky bits and rule-locking bypass. It sits between the CSR access path and the PMP checker.

## Interface

Parameters:
- `PMPGranularity`, 0: NAPOT granule, 0 = 4 B, G = 2^(G+2) B.
- `PMPNumRegions`, 4: implemented entries, 1..16.

Ports:
- `clk_i`  in  1  clock.
- `rst_i`  in  1  reset; asynchronous, active-high.
- `csr_we_i`  in  1  write strobe, one access per cycle.
- `csr_addr_i`  in  12  CSR address.
- `csr_wdata_i`  in  32  write data.
- `csr_rdata_o`  out  32  read data for `csr_addr_i`, combinational.
- `csr_hit_o`  out  1  `csr_addr_i` is in PMP CSR space (0x3A0–0x3A3, 0x3B0–0x3BF, 0x747).
- `csr_wr_ignored_o`  out  1  registered one-cycle pulse: the previous write to a hit address changed no state because of a lock or WARL rule.
- `csr_pmp_cfg_o[PMPNumRegions]`  out  pmp_cfg_t  per-entry lock, mode, exec, write, read.
- `csr_pmp_addr_o[PMPNumRegions]`  out  34  `{pmpaddr[31:0], 2'b00}`.
- `csr_pmp_mseccfg_o`  out  pmp_mseccfg_t  mml, mmwp, rlb.

## Operation

CSR map:
- `pmpcfg0..3` at 0x3A0+k. Byte j holds entry 4k+j.
  - Byte layout: bit7 L, bits6:5 zero, bits4:3 A (mode), bit2 X, bit1 W, bit0 R.
  - Bytes for entries ≥ PMPNumRegions read 0; writes to them are dropped.
- `pmpaddr0..15` at 0x3B0+i hold addr[33:2]. Unimplemented entries read 0.
- `mseccfg` at 0x747: bit0 MML, bit1 MMWP, bit2 RLB. Other bits read 0.

Locked definition: `locked(i) = cfg[i].L & ~rlb`. Every rule below is evaluated against pre-write state.

`pmpcfg` byte write to entry i is dropped whole when any of these holds:
- `locked(i)`.
- `~mml` and the new byte has R=0, W=1 (reserved encoding).
- `mml & ~rlb` and the new byte has L=1, X=1, and is not R=0, W=1 (no new M-mode executable rule).

Mode legalisation: if `PMPGranularity>0` and the new A field is NA4, store OFF. Bytes within one word are handled independently.

`pmpaddr[i]` write is dropped when either holds:
- `locked(i)`.
- `i+1 < PMPNumRegions` and `cfg[i+1].mode==TOR` and `locked(i+1)`.

`pmpaddr` read for `PMPGranularity≥1`:
- NAPOT entry: bits [G-2:0] read 1.
- OFF/TOR entry: bits [G-1:0] read 0.
- Stored value is unchanged by the read mask.

`mseccfg` write:
- MML and MMWP are sticky: a write of 1 sets them, a write of 0 has no effect, and only reset clears them.
- RLB takes the written value only if RLB is currently 1 or no implemented entry has L=1. Otherwise RLB is unchanged.

`csr_wr_ignored_o` asserts when any byte or field of the write was dropped. A partially dropped `pmpcfg` word also asserts it.

## Timing

- Reset values: all cfg 0 (OFF), all addr 0, mseccfg 0, `csr_wr_ignored_o` 0.
- A write updates state on the next rising `clk_i` edge.
  - Configuration outputs reflect it 1 cycle after the strobe.
  - A same-address read in the write cycle returns the old value.
- `csr_rdata_o` and `csr_hit_o` are combinational from `csr_addr_i` and current state. `csr_rdata_o` is 0 when there is no hit.
- Configuration outputs come straight from flops, with no combinational path from `csr_wdata_i`.
- `rst_i` asserted mid-sequence clears all state immediately (asynchronous). The first write after deassertion is honoured normally.
- `csr_we_i` with a non-hit address changes no state and does not pulse `csr_wr_ignored_o`.

## Test plan

- Reset then read all PMP CSRs -> every read is 0; cfg outputs OFF; `csr_pmp_addr_o[i]`=0.
- Lock behaviour:
  - Write `pmpcfg0`=0x0000_0089 (entry0 TOR, L, R), then `pmpaddr0`=0x1234 -> `pmpaddr0` reads 0 and `csr_wr_ignored_o` pulses.
  - Write `pmpcfg0` byte0=0x00 -> byte0 stays 0x89.
- TOR lock-through: entry1 = 0x89 (TOR, L) with RLB=0 -> write to `pmpaddr0` ignored; write to `pmpaddr2` accepted.
- Reserved encoding: MML=0, write byte 0x02 (R=0, W=1) -> byte unchanged and ignore pulse. Set MML=1, rewrite -> byte reads 0x02.
- Sticky and RLB:
  - Write `mseccfg`=0x3, then 0x0 -> reads 0x3.
  - With an entry locked, write RLB=1 -> RLB stays 0.
  - After reset with no locks, write RLB=1, then lock entry0 -> later writes to entry0 are accepted.
- Granularity G=2: write NA4 mode -> mode reads OFF. NAPOT with `pmpaddr0`=0x1000 -> read 0x1001.
